// File: rtl/timer_prog_sequencer.sv
// timer_prog_sequencer
// Accepts one programming request (counter select, mode, count) per
// handshake, validates it against the timer's rules and serialises valid
// requests onto the timer's 4-bit data / 2-bit address bus as a control
// write followed by the high and low count nibbles. Completion or rejection
// is reported with a one-cycle done pulse qualified by err / err_code.
module timer_prog_sequencer #(
  parameter int C0_MIN   = 2,
  parameter int C0_MAX   = 150,
  parameter int C1_MIN   = 50,
  parameter int C1_MAX   = 200,
  parameter int IDLE_GAP = 1,
  parameter int CHECK_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_sel,
  input  logic [2:0] req_mode,
  input  logic [7:0] req_count,
  output logic [3:0] d,
  output logic [1:0] a,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  // A gap shorter than one cycle would let two writes abut, so clamp it.
  localparam int         GAP_N    = (IDLE_GAP < 1) ? 1 : IDLE_GAP;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_N - 1);

  localparam logic [7:0] C0_MIN_B = 8'(C0_MIN);
  localparam logic [7:0] C0_MAX_B = 8'(C0_MAX);
  localparam logic [7:0] C1_MIN_B = 8'(C1_MIN);
  localparam logic [7:0] C1_MAX_B = 8'(C1_MAX);

  localparam logic [1:0] A_CNT0 = 2'b00;
  localparam logic [1:0] A_CTRL = 2'b10;
  localparam logic [1:0] A_IDLE = 2'b11;

  localparam logic [1:0] E_NONE   = 2'b00;
  localparam logic [1:0] E_MODE   = 2'b01;
  localparam logic [1:0] E_RANGE  = 2'b10;
  localparam logic [1:0] E_PARITY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_HI,
    S_LO,
    S_GAP,
    S_ERR
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] gap_reg, gap_next;
  logic       sel_reg;
  logic [7:0] count_reg;

  logic [3:0] d_reg, d_next;
  logic [1:0] a_reg, a_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;
  logic [1:0] err_code_reg, err_code_next;

  logic       accept;
  logic       in_range;
  logic       bad_parity;
  logic [1:0] chk_code;

  assign req_ready = (state_reg == S_IDLE) && rst_n;
  assign busy      = (state_reg != S_IDLE);
  assign accept    = req_valid && req_ready;

  assign d        = d_reg;
  assign a        = a_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;

  // Classify the request currently presented; mode beats range beats parity.
  always_comb begin
    chk_code   = E_NONE;
    in_range   = req_sel ? ((req_count >= C1_MIN_B) && (req_count <= C1_MAX_B))
                         : ((req_count >= C0_MIN_B) && (req_count <= C0_MAX_B));
    bad_parity = ((req_mode == 3'd2) && req_count[0]) ||
                 (((req_mode == 3'd3) || (req_mode == 3'd4)) && !req_count[0]);
    if (CHECK_EN != 0) begin
      if (req_mode > 3'd4) begin
        chk_code = E_MODE;
      end else if (!in_range) begin
        chk_code = E_RANGE;
      end else if (bad_parity) begin
        chk_code = E_PARITY;
      end
    end
  end

  // Next state plus the bus/status values the next state presents, so the
  // outputs come straight from flops and line up with the state they belong to.
  always_comb begin
    state_next    = state_reg;
    gap_next      = gap_reg;
    a_next        = A_IDLE;
    d_next        = 4'd0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (chk_code == E_NONE) begin
            state_next = S_CTRL;
            a_next     = A_CTRL;
            d_next     = {req_sel, req_mode};
          end else begin
            state_next    = S_ERR;
            done_next     = 1'b1;
            err_next      = 1'b1;
            err_code_next = chk_code;
          end
        end
      end
      S_CTRL: begin
        state_next = S_HI;
        a_next     = A_CNT0 | {1'b0, sel_reg};
        d_next     = count_reg[7:4];
      end
      S_HI: begin
        state_next = S_LO;
        a_next     = A_CNT0 | {1'b0, sel_reg};
        d_next     = count_reg[3:0];
      end
      S_LO: begin
        state_next    = S_GAP;
        gap_next      = GAP_LOAD;
        done_next     = 1'b1;
        err_code_next = E_NONE;
      end
      S_GAP: begin
        if (gap_reg == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_reg - 8'd1;
        end
      end
      S_ERR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, gap counter and registered outputs; reset aborts any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      gap_reg      <= 8'd0;
      a_reg        <= A_IDLE;
      d_reg        <= 4'd0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= E_NONE;
    end else begin
      state_reg    <= state_next;
      gap_reg      <= gap_next;
      a_reg        <= a_next;
      d_reg        <= d_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  // Capture the request fields needed for the nibble cycles at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg   <= 1'b0;
      count_reg <= 8'd0;
    end else if (accept) begin
      sel_reg   <= req_sel;
      count_reg <= req_count;
    end
  end

endmodule

// File: tb/tb_timer_prog_sequencer.sv
// Directed bench for timer_prog_sequencer: three instances share one set of
// request inputs (default, IDLE_GAP = 2, CHECK_EN = 0); each scenario checks
// only the instance it targets.
module tb_timer_prog_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_sel;
  logic [2:0] req_mode;
  logic [7:0] req_count;

  logic       ready0, busy0, done0, err0;
  logic [3:0] d0;
  logic [1:0] a0, code0;
  logic       ready_g, busy_g, done_g, err_g;
  logic [3:0] d_g;
  logic [1:0] a_g, code_g;
  logic       ready_n, busy_n, done_n, err_n;
  logic [3:0] d_n;
  logic [1:0] a_n, code_n;

  int checks_cnt;
  int fail_cnt;

  timer_prog_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0),
    .req_sel(req_sel), .req_mode(req_mode), .req_count(req_count),
    .d(d0), .a(a0), .busy(busy0), .done(done0), .err(err0), .err_code(code0)
  );

  timer_prog_sequencer #(.IDLE_GAP(2)) dut_g2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_g),
    .req_sel(req_sel), .req_mode(req_mode), .req_count(req_count),
    .d(d_g), .a(a_g), .busy(busy_g), .done(done_g), .err(err_g), .err_code(code_g)
  );

  timer_prog_sequencer #(.CHECK_EN(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_n),
    .req_sel(req_sel), .req_mode(req_mode), .req_count(req_count),
    .d(d_n), .a(a_n), .busy(busy_n), .done(done_n), .err(err_n), .err_code(code_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch on one line.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Present a request and let it be taken on the next edge.
  task automatic issue(input logic sel, input logic [2:0] mode, input logic [7:0] count);
    req_sel   = sel;
    req_mode  = mode;
    req_count = count;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic expect_reject(input string tag, input logic sel, input logic [2:0] mode,
                               input logic [7:0] count, input logic [1:0] code);
    check({tag, "_ready"}, ready0, 1'b1);
    issue(sel, mode, count);
    check({tag, "_done"}, done0, 1'b1);
    check({tag, "_err"}, err0, 1'b1);
    check({tag, "_code"}, code0, code);
    check({tag, "_a"}, a0, 2'b11);
    step();
    check({tag, "_ready2"}, ready0, 1'b1);
    check({tag, "_done_low"}, done0, 1'b0);
    check({tag, "_code_held"}, code0, code);
    check({tag, "_a2"}, a0, 2'b11);
  endtask

  int         ctrl_t[2];
  int         n_ctrl;
  logic [1:0] a_hist[40];
  logic [3:0] d_second;

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    req_sel    = 1'b0;
    req_mode   = 3'd0;
    req_count  = 8'd0;
    req_valid  = 1'b0;
    rst_n      = 1'b0;

    // Reset values while rst_n is low.
    step();
    check("rst_a", a0, 2'b11);
    check("rst_d", d0, 4'd0);
    check("rst_done", done0, 1'b0);
    check("rst_err", err0, 1'b0);
    check("rst_code", code0, 2'b00);
    check("rst_ready", ready0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    step();

    // sel0 mode2 count 0x64.
    check("w1_ready", ready0, 1'b1);
    issue(1'b0, 3'd2, 8'd100);
    check("w1_ctrl_a", a0, 2'b10);
    check("w1_ctrl_d", d0, 4'b0010);
    check("w1_busy", busy0, 1'b1);
    check("w1_ready_low", ready0, 1'b0);
    step();
    check("w1_hi_a", a0, 2'b00);
    check("w1_hi_d", d0, 4'b0110);
    step();
    check("w1_lo_a", a0, 2'b00);
    check("w1_lo_d", d0, 4'b0100);
    step();
    check("w1_gap_a", a0, 2'b11);
    check("w1_done", done0, 1'b1);
    check("w1_err", err0, 1'b0);
    step();
    check("w1_ready_back", ready0, 1'b1);
    check("w1_done_pulse", done0, 1'b0);

    // Rejections.
    expect_reject("rj_range", 1'b1, 3'd3, 8'd201, 2'b10);
    expect_reject("rj_mode", 1'b0, 3'd5, 8'd100, 2'b01);
    expect_reject("rj_parity", 1'b0, 3'd4, 8'd8, 2'b11);
    expect_reject("rj_c0_low", 1'b0, 3'd0, 8'd1, 2'b10);

    // sel1 mode0 count 0x32; successful done clears err_code.
    issue(1'b1, 3'd0, 8'd50);
    check("w2_ctrl_a", a0, 2'b10);
    check("w2_ctrl_d", d0, 4'b1000);
    step();
    check("w2_hi_a", a0, 2'b01);
    check("w2_hi_d", d0, 4'b0011);
    step();
    check("w2_lo_a", a0, 2'b01);
    check("w2_lo_d", d0, 4'b0010);
    step();
    check("w2_done", done0, 1'b1);
    check("w2_err", err0, 1'b0);
    check("w2_code_clear", code0, 2'b00);

    // Reset during the HI cycle.
    do_reset();
    issue(1'b0, 3'd2, 8'd100);
    step();
    check("mr_hi_a", a0, 2'b00);
    rst_n = 1'b0;
    #1;
    check("mr_a", a0, 2'b11);
    check("mr_d", d0, 4'd0);
    check("mr_busy", busy0, 1'b0);
    check("mr_done", done0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("mr_no_done", done0, 1'b0);
    check("mr_ready", ready0, 1'b1);
    issue(1'b1, 3'd0, 8'd50);
    check("mr_new_ctrl", a0, 2'b10);
    step();
    step();
    step();
    check("mr_new_done", done0, 1'b1);
    check("mr_new_err", err0, 1'b0);

    // Back-to-back on the IDLE_GAP = 2 instance with req_valid held high.
    do_reset();
    n_ctrl    = 0;
    req_sel   = 1'b0;
    req_mode  = 3'd2;
    req_count = 8'd100;
    req_valid = 1'b1;
    d_second  = 4'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      a_hist[cyc] = a_g;
      if (a_g == 2'b10 && n_ctrl < 2) begin
        ctrl_t[n_ctrl] = cyc;
        if (n_ctrl == 1) begin
          d_second  = d_g;
          req_valid = 1'b0;
        end
        n_ctrl++;
        req_sel   = 1'b1;
        req_mode  = 3'd0;
        req_count = 8'd50;
      end
    end
    req_valid = 1'b0;
    check("b2b_ctrl_count", n_ctrl, 2);
    if (n_ctrl == 2) begin
      check("b2b_spacing", ctrl_t[1] - ctrl_t[0], 6);
      check("b2b_second_d", d_second, 4'b1000);
      check("b2b_lo_a", a_hist[ctrl_t[0] + 2], 2'b00);
      check("b2b_gap1_a", a_hist[ctrl_t[0] + 3], 2'b11);
      check("b2b_gap2_a", a_hist[ctrl_t[0] + 4], 2'b11);
    end

    // CHECK_EN = 0 forwards an otherwise illegal request.
    do_reset();
    issue(1'b0, 3'd7, 8'd1);
    check("nc_ctrl_a", a_n, 2'b10);
    check("nc_ctrl_d", d_n, 4'b0111);
    check("nc_ref_err", err0, 1'b1);
    check("nc_ref_code", code0, 2'b01);
    step();
    check("nc_hi_a", a_n, 2'b00);
    check("nc_hi_d", d_n, 4'b0000);
    step();
    check("nc_lo_a", a_n, 2'b00);
    check("nc_lo_d", d_n, 4'b0001);
    step();
    check("nc_done", done_n, 1'b1);
    check("nc_err", err_n, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
